// File: rtl/sigmoid_idx_stage.sv
// sigmoid_idx_stage: front end of the sigmoid activation path.
// Quantises a signed sample into a sigmoid table index, presents that index
// to the external combinational table and registers the returned word.
// Two-stage valid/ready pipeline, 1 sample/cycle, 2-cycle latency.
// Optional build macro SIGMOID_SATCNT_EN adds the sat_count port, which
// counts accepted samples whose index had to be clamped.
module sigmoid_idx_stage #(
  parameter int DATA_W  = 16,
  parameter int SHIFT   = 10,
  parameter int OFFSET  = 5,
  parameter int IDX_MAX = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic [4:0]               tbl_idx,
  input  logic [DATA_W-1:0]        tbl_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     frame_done
`ifdef SIGMOID_SATCNT_EN
  ,
  output logic [15:0]              sat_count
`endif
);

  // One extra bit of headroom so shift-plus-bias never wraps.
  localparam logic signed [DATA_W:0] OFF_X     = (DATA_W+1)'(OFFSET);
  localparam logic signed [DATA_W:0] IDX_MAX_X = (DATA_W+1)'(IDX_MAX);
  localparam logic [4:0]             IDX_MAX_5 = 5'(IDX_MAX);

  function automatic logic signed [DATA_W:0] bias_shift(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] s;
    s = {x[DATA_W-1], x};
    return (s >>> SHIFT) + OFF_X;
  endfunction

  function automatic logic [4:0] sat_idx(input logic signed [DATA_W:0] t);
    if (t[DATA_W])
      return 5'd0;
    else if (t > IDX_MAX_X)
      return IDX_MAX_5;
    else
      return t[4:0];
  endfunction

  logic signed [DATA_W:0] biased_p0;
  logic [4:0]             idx_p0;
  logic                   adv1;
  logic                   adv2;

  logic                   vld_p1;
  logic [4:0]             idx_p1;
  logic                   last_p1;

  assign biased_p0 = bias_shift(in_data);
  assign idx_p0    = sat_idx(biased_p0);

  // Stage 2 advances when its word is taken or it is empty; stage 1 follows.
  assign adv2     = out_ready | ~out_valid;
  assign adv1     = adv2 | ~vld_p1;
  assign in_ready = adv1;
  assign tbl_idx  = idx_p1;

  // ---- stage 1: quantised index register, drives the table ----
  // Capture the index and frame marker of each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      idx_p1  <= 5'd0;
      last_p1 <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        idx_p1  <= idx_p0;
        last_p1 <= in_last;
      end
    end
  end

  // ---- stage 2: registered table word towards the next layer ----
  // Register the table word returned for the stage-1 index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (adv2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= tbl_value;
        out_last <= last_p1;
      end
    end
  end

  // Pulse once, the cycle after the last sample of a frame is handed off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_done <= 1'b0;
    else
      frame_done <= out_valid & out_ready & out_last;
  end

`ifdef SIGMOID_SATCNT_EN
  function automatic logic is_clamped(input logic signed [DATA_W:0] t);
    return t[DATA_W] | (t > IDX_MAX_X);
  endfunction

  logic sat_inc;
  assign sat_inc = in_valid & in_ready & is_clamped(biased_p0);

  // Per-frame clamp counter; sticks at all-ones, restarts after frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_count <= 16'd0;
    else if (frame_done)
      sat_count <= sat_inc ? 16'd1 : 16'd0;
    else if (sat_inc && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sigmoid_idx_stage.sv
// Directed bench for sigmoid_idx_stage: mapping table, reset, full-rate
// streaming, backpressure and frame handling, plus the optional clamp counter.
module tb_sigmoid_idx_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [4:0]  tbl_idx;
  logic [15:0] tbl_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        frame_done;
`ifdef SIGMOID_SATCNT_EN
  logic [15:0] sat_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sigmoid_idx_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .tbl_idx    (tbl_idx),
    .tbl_value  (tbl_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done)
`ifdef SIGMOID_SATCNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  // Production sigmoid table stand-in (combinational).
  function automatic logic [15:0] tbl(input logic [4:0] i);
    case (i)
      5'd0: return 16'h5800;
      5'd1: return 16'h1800;
      5'd2: return 16'h2000;
      5'd3: return 16'h2400;
      5'd4: return 16'h2800;
      5'd5: return 16'h2C00;
      5'd6: return 16'h3000;
      5'd7: return 16'h3400;
      5'd8: return 16'h3600;
      5'd9: return 16'h3800;
      default: return 16'h0000;
    endcase
  endfunction

  assign tbl_value = tbl(tbl_idx);

  // Reference index: floor(x / 1024) + 5, clamped to 0..9.
  function automatic int model_idx(input logic [15:0] d);
    int x, s, t;
    x = int'($signed(d));
    s = (x - (((x % 1024) + 1024) % 1024)) / 1024;
    t = s + 5;
    if (t < 0) t = 0;
    if (t > 9) t = 9;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] din;
    logic [4:0]  idx;
    logic [15:0] dout;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } ent_t;

  ent_t        exp_q[$];
  logic [15:0] sdata[16];
  logic        slast[16];

  // Drive sdata[0..n-1] through the stage with an optional out_ready stall,
  // scoreboarding every output handshake and every frame_done cycle.
  task automatic stream(input int n, input int stall_at, input int stall_len,
                        input bit chk_rate, output int fd_cnt);
    int   i    = 0;
    int   cyc  = 0;
    bit   fd_exp = 1'b0;
    logic [15:0] held = '0;
    ent_t e;
    fd_cnt = 0;
    while ((i < n || exp_q.size() != 0) && cyc < 200) begin
      in_valid  = (i < n);
      in_data   = (i < n) ? sdata[i] : 16'h0000;
      in_last   = (i < n) ? slast[i] : 1'b0;
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      check("frame_done", frame_done, fd_exp);
      if (frame_done) fd_cnt++;
      if (chk_rate && i < n) check("b2b_in_ready", in_ready, 1'b1);
      if (cyc == stall_at) held = out_data;
      if (cyc > stall_at && cyc < stall_at + stall_len) begin
        check("stall_out_data_hold", out_data, held);
        check("stall_in_ready", in_ready, 1'b0);
      end
      fd_exp = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back('{d: tbl(5'(model_idx(sdata[i]))), l: slast[i]});
        i++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("dup_output", out_data, 16'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("stream_out_data", out_data, e.d);
          check("stream_out_last", out_last, e.l);
          fd_exp = out_last;
        end
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stream_drained", (i == n && exp_q.size() == 0), 1'b1);
    if (chk_rate) check("b2b_cycles", cyc, n + 2);
    check("frame_done_tail", frame_done, fd_exp);
    if (frame_done) fd_cnt++;
    step();
    check("frame_done_clear", frame_done, 1'b0);
  endtask

  vec_t vecs[12];
  int   fd;

  initial begin
    vecs[0]  = '{16'h0000, 5'd5, 16'h2C00};
    vecs[1]  = '{16'h0400, 5'd6, 16'h3000};
    vecs[2]  = '{16'hFFFF, 5'd4, 16'h2800};
    vecs[3]  = '{16'h8000, 5'd0, 16'h5800};
    vecs[4]  = '{16'h7FFF, 5'd9, 16'h3800};
    vecs[5]  = '{16'hFC00, 5'd4, 16'h2800};
    vecs[6]  = '{16'h0BFF, 5'd7, 16'h3400};
    vecs[7]  = '{16'hEC00, 5'd0, 16'h5800};
    vecs[8]  = '{16'hE800, 5'd0, 16'h5800};
    vecs[9]  = '{16'h1000, 5'd9, 16'h3800};
    vecs[10] = '{16'h1400, 5'd9, 16'h3800};
    vecs[11] = '{16'h0FFF, 5'd8, 16'h3600};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_tbl_idx", tbl_idx, 5'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_last", out_last, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);
    step();

    // Single-sample mapping vectors.
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_data  = vecs[k].din;
      #1;
      check("map_in_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("map_tbl_idx", tbl_idx, vecs[k].idx);
      step();
      check("map_out_valid", out_valid, 1'b1);
      check("map_out_data", out_data, vecs[k].dout);
      step();
      check("map_out_idle", out_valid, 1'b0);
    end

    // Asynchronous reset with both stages full.
    in_valid = 1'b1; in_data = 16'h0000; step();
    in_data = 16'h0400; step();
    in_valid = 1'b0;
    check("pre_rst_out_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_frame_done", frame_done, 1'b0);
    check("async_rst_tbl_idx", tbl_idx, 5'd0);
    @(posedge clk); #1;
    check("rst_held_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_no_output", out_valid, 1'b0);
    end

    // Back-to-back stream of 8 samples.
    for (int k = 0; k < 8; k++) begin
      sdata[k] = 16'(k * 16'h0900 - 16'h2000);
      slast[k] = 1'b0;
    end
    stream(8, -1, 0, 1'b1, fd);
    check("b2b_frame_done_count", fd, 0);

    // Backpressure: 5 stalled cycles mid-stream, distinct table words.
    for (int k = 0; k < 10; k++) begin
      sdata[k] = 16'(k * 16'h0400 - 16'h1400);
      slast[k] = 1'b0;
    end
    stream(10, 3, 5, 1'b0, fd);

    // Four-sample frame.
    sdata[0] = 16'h0000; sdata[1] = 16'h8000; sdata[2] = 16'h0400; sdata[3] = 16'h7FFF;
    slast[0] = 1'b0; slast[1] = 1'b0; slast[2] = 1'b0; slast[3] = 1'b1;
    stream(4, -1, 0, 1'b0, fd);
    check("frame_done_count", fd, 1);

    // in_last without in_valid is ignored.
    in_valid = 1'b0; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("stray_last_frame_done", frame_done, 1'b0);
      check("stray_last_out_valid", out_valid, 1'b0);
    end
    in_last = 1'b0;

`ifdef SIGMOID_SATCNT_EN
    rst = 1'b1; step(); rst = 1'b0;
    check("satcnt_rst", sat_count, 16'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h8000; in_last = 1'b0; step();
    in_data = 16'h0000; step();
    in_data = 16'h7FFF; in_last = 1'b1; step();
    in_valid = 1'b0; in_last = 1'b0;
    check("satcnt_two", sat_count, 16'd2);
    step();
    check("satcnt_before_fd", sat_count, 16'd2);
    check("satcnt_fd_low", frame_done, 1'b0);
    step();
    check("satcnt_fd_pulse", frame_done, 1'b1);
    check("satcnt_during_fd", sat_count, 16'd2);
    step();
    check("satcnt_cleared", sat_count, 16'd0);
    check("satcnt_fd_end", frame_done, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sigmoid_idx_stage.md
Name: sigmoid_idx_stage

Overview:
- Pipelined front end of the sigmoid activation path.
- Quantises each signed 16-bit convolution/accumulator sample into a 5-bit table index (0..9), drives the combinational sigmoid table's index input, and registers the returned 16-bit table word.
- Streams results downstream to the next layer with valid/ready flow control.
- Throughput 1 sample/cycle, 2-cycle latency.

Parameters:
- DATA_W, 16, width of input sample and table word
- SHIFT, 10, arithmetic right-shift applied to the input (bucket width 2^SHIFT)
- OFFSET, 5, signed bias added after the shift so that x=0 maps to the table midpoint
- IDX_MAX, 9, highest valid table index; clamp ceiling

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  stage can accept a sample this cycle
- in_data  in  DATA_W  signed two's-complement sample
- in_last  in  1  marks last sample of a feature map
- tbl_idx  out  5  index driven to the sigmoid table (registered stage-1 index)
- tbl_value  in  DATA_W  combinational table output for tbl_idx
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  registered table word
- out_last  out  1  in_last delayed with its sample
- frame_done  out  1  one-cycle pulse on the output handshake of a sample with out_last=1

Behaviour:
- Reset (async, rst=1): s1_valid, out_valid, out_last, frame_done = 0; s1_idx, tbl_idx, out_data = 0. Outputs stay at these values while rst is high. Reset mid-stream discards all in-flight samples; no partial output after release.
- Index arithmetic (stage 1):
  - s = in_data >>> SHIFT (sign-preserving), extended to 17-bit signed.
  - t = s + OFFSET.
  - If t < 0, idx = 0 (sat_lo).
  - Else if t > IDX_MAX, idx = IDX_MAX (sat_hi).
  - Else idx = t[4:0].
  - No wrap-around is permitted for any DATA_W input.
- Pipeline control:
  - adv2 = out_ready | ~out_valid
  - adv1 = adv2 | ~s1_valid
  - in_ready = adv1 (combinational, no dependence on in_valid)
- Stage 1 (on adv1): s1_valid <= in_valid; when in_valid, s1_idx <= idx and s1_last <= in_last. tbl_idx = s1_idx.
- Stage 2 (on adv2): out_valid <= s1_valid; when s1_valid, out_data <= tbl_value and out_last <= s1_last.
- Latency: a sample accepted at edge N has out_valid=1 after edge N+1.
- Stall: while out_valid & ~out_ready, out_data, out_last and tbl_idx are held. One sample is held in stage 1 and in_ready=0 once stage 1 is full. No data is lost or duplicated.
- Simultaneous output handshake and input accept in the same cycle sustains full rate.
- frame_done <= out_valid & out_ready & out_last, registered, so it pulses the cycle after the handshake. It is otherwise 0.
- in_last with in_valid=0 is ignored.

Optional Feature:
- Macro SIGMOID_SATCNT_EN.
- When defined:
  - Adds output port sat_count (16 bits). It counts samples accepted at the input (in_valid & in_ready) whose index was clamped (sat_lo or sat_hi).
  - The counter saturates at 16'hFFFF and does not wrap.
  - Cleared by rst. Also cleared on the cycle frame_done is asserted; an increment in that same cycle loads 1.
- When undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle -> out_valid=0, frame_done=0, tbl_idx=0 immediately; in_ready=1 after release.
- Mapping (defaults, out_ready=1), expected idx -> out_data with the production table:
  - 16'h0000 -> idx 5 -> 16'h2C00
  - 16'h0400 -> idx 6 -> 16'h3000
  - 16'hFFFF -> idx 4 -> 16'h2800
  - 16'h8000 -> idx 0 -> 16'h5800
  - 16'h7FFF -> idx 9 -> 16'h3800
  - Each appears 2 cycles after acceptance.
- Back-to-back stream of 8 samples with out_ready=1 -> in_ready stays 1 and 8 outputs arrive on consecutive cycles in order.
- Backpressure: out_ready=0 for 5 cycles during a stream -> out_data held constant, in_ready drops after stage 1 fills, no loss or duplication after out_ready returns.
- Frame: 4-sample frame with in_last on the 4th -> out_last on the 4th output, frame_done pulses exactly once, one cycle after that handshake.
- SIGMOID_SATCNT_EN: frame of 16'h8000, 16'h0000, 16'h7FFF -> sat_count=2 before frame_done, 0 after.
